cpu_datapath: RTL and testbench
===============================

// Module: cpu_datapath
// PURPOSE
//  Register/bus datapath driven by the controller's control strobes; consumer of its outputs, producer of its instr input.
//  Holds AR, PC, DR, TR, IR, R, AC and the Z flag around one shared internal bus; contains the 8-bit ALU.
//  Drives the external memory address/data; returns IR (instr) and Z to the controller each cycle.
// PARAMETERS
//  DATA_W  8   data register / ALU / memory data width
//  ADDR_W  16  AR, PC and internal bus width (>= 2*DATA_W)
// PORTS
//  clk        in   1       system clock, rising edge
//  rst        in   1       reset, synchronous, active-low
//  ARload     in   1       AR <= bus[ADDR_W-1:0]
//  ARinc      in   1       AR <= AR+1
//  PCload     in   1       PC <= bus
//  PCinc      in   1       PC <= PC+1
//  DRload     in   1       DR <= bus[DATA_W-1:0]
//  TRload     in   1       TR <= DR
//  IRload     in   1       IR <= bus[DATA_W-1:0]
//  Rload      in   1       R <= bus[DATA_W-1:0]
//  ACload     in   1       AC <= alu_out
//  Zload      in   1       z <= (alu_out == 0)
//  PCbus      in   1       bus driver: PC
//  DRhbus     in   1       bus driver: {DR,TR} (DR high byte)
//  DRlbus     in   1       bus driver: zero-extended DR
//  TRbus      in   1       bus driver: zero-extended TR
//  Rbus       in   1       bus driver: zero-extended R
//  ACbus      in   1       bus driver: zero-extended AC
//  mem2bus    in   1       bus driver: zero-extended mem_rdata
//  bus2mem    in   1       memory write strobe
//  alus       in   4       ALU op select
//  mem_addr   out  ADDR_W  = AR
//  mem_wdata  out  DATA_W  = bus[DATA_W-1:0]
//  mem_we     out  1       = bus2mem
//  mem_rdata  in   DATA_W  asynchronous read data for mem_addr
//  instr      out  DATA_W  = IR
//  z          out  1       zero flag
//  ac         out  DATA_W  = AC (debug / display)
// BEHAVIOUR
//  - Reset: on posedge clk with rst=0 -> AR,PC,DR,TR,IR,R,AC=0, z=0; controls ignored that edge; mid-instruction reset allowed.
//  - Bus: combinational OR-free mux; no driver asserted -> bus=0.
//  - Driver priority (multiple asserted, macro off): mem2bus > PCbus > DRhbus > DRlbus > TRbus > Rbus > ACbus.
//  - All register loads on posedge clk, one-cycle latency; loads sample the bus value of the same cycle.
//  - ARload & ARinc together: load wins; PCload & PCinc: load wins.
//  - AR/PC increment wraps 2^ADDR_W-1 -> 0; no carry out.
//  - TRload & DRload same cycle: TR gets old DR (pipeline transfer).
//  - ALU: a=AC, b=bus[DATA_W-1:0]; result truncated to DATA_W, no carry/overflow kept.
//    alus 0 PASS b | 1 a+b | 2 a-b | 3 a+1 | 4 CLR 0 | 5 a&b | 6 a|b | 7 a^b | 8 ~a | 9-15 hold (alu_out=AC).
//  - Zload independent of ACload; z reflects alu_out of the same cycle, not the new AC.
//  - Memory: mem_we combinational from bus2mem; write data is current bus; read data valid same cycle.
//  - bus2mem & mem2bus same cycle is illegal; mem_we forced 0 that cycle.
// CONFIGURATION
//  BUS_CHECK_EN defined: adds output bus_err (1 bit), sticky, set at posedge when >1 bus driver asserted;
//   that cycle bus forced 0 (no priority); cleared only by reset.
//  BUS_CHECK_EN undefined: no bus_err port; priority order above applies silently.
// TESTING
//  - Reset: load all regs nonzero, rst=0 one edge -> all regs 0, z=0, instr=0, mem_addr=0.
//  - Fetch: PC=0x0005, PCbus+ARload; then mem_rdata=0x0A, mem2bus+DRload+PCinc; then DRlbus+IRload -> AR=0x0005, PC=0x0006, instr=0x0A.
//  - ALU: AC=0x7F, R=0x01, Rbus+alus=1+ACload+Zload -> AC=0x80, z=0; repeat alus=2 with bus=0x80 -> AC=0x00, z=1.
//  - Wrap: PC=0xFFFF, PCinc -> PC=0x0000; PCload(bus=0x1234)+PCinc -> PC=0x1234.
//  - Store: AR=0x0040, AC=0x5A, ACbus+bus2mem -> mem_we=1, mem_addr=0x0040, mem_wdata=0x5A same cycle.
//  - Conflict: PCbus+ACbus together, ARload -> macro off: AR=PC; macro on: AR=0, bus_err=1, stays 1 until rst=0.

Source files
------------

// File: rtl/cpu_datapath.sv
`default_nettype none
// ============================================================================
// Module   : cpu_datapath
// Purpose  : Shared-bus register datapath (AR, PC, DR, TR, IR, R, AC, Z) with
//            an 8-bit ALU. Optional macro BUS_CHECK_EN adds a sticky bus_err
//            output and forces the bus to zero when drivers collide.
// Revision : 1.0  initial release
// ============================================================================
module cpu_datapath #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ARload,
    input  logic              ARinc,
    input  logic              PCload,
    input  logic              PCinc,
    input  logic              DRload,
    input  logic              TRload,
    input  logic              IRload,
    input  logic              Rload,
    input  logic              ACload,
    input  logic              Zload,
    input  logic              PCbus,
    input  logic              DRhbus,
    input  logic              DRlbus,
    input  logic              TRbus,
    input  logic              Rbus,
    input  logic              ACbus,
    input  logic              mem2bus,
    input  logic              bus2mem,
    input  logic [3:0]        alus,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] instr,
    output logic              z,
`ifdef BUS_CHECK_EN
    output logic              bus_err,
`endif
    output logic [DATA_W-1:0] ac
);

    localparam logic [DATA_W-1:0] C_ONE_D = DATA_W'(1);
    localparam logic [ADDR_W-1:0] C_ONE_A = ADDR_W'(1);

    logic [ADDR_W-1:0] r_ar;
    logic [ADDR_W-1:0] r_pc;
    logic [DATA_W-1:0] r_dr;
    logic [DATA_W-1:0] r_tr;
    logic [DATA_W-1:0] r_ir;
    logic [DATA_W-1:0] r_r;
    logic [DATA_W-1:0] r_ac;
    logic              r_z;

    logic [ADDR_W-1:0] w_bus_pri;
    logic [ADDR_W-1:0] w_bus;
    logic [DATA_W-1:0] w_b;
    logic [DATA_W-1:0] w_alu;

    always_comb begin
        w_bus_pri = '0;
        if (mem2bus)     w_bus_pri = ADDR_W'(mem_rdata);
        else if (PCbus)  w_bus_pri = r_pc;
        else if (DRhbus) w_bus_pri = ADDR_W'({r_dr, r_tr});
        else if (DRlbus) w_bus_pri = ADDR_W'(r_dr);
        else if (TRbus)  w_bus_pri = ADDR_W'(r_tr);
        else if (Rbus)   w_bus_pri = ADDR_W'(r_r);
        else if (ACbus)  w_bus_pri = ADDR_W'(r_ac);
    end

`ifdef BUS_CHECK_EN
    logic [6:0] w_drv;
    logic       w_multi;
    logic       r_bus_err;

    // More than one bit set <=> clearing the lowest set bit leaves something.
    assign w_drv   = {mem2bus, PCbus, DRhbus, DRlbus, TRbus, Rbus, ACbus};
    assign w_multi = |(w_drv & (w_drv - 7'd1));
    assign w_bus   = w_multi ? '0 : w_bus_pri;
    assign bus_err = r_bus_err;

    always_ff @(posedge clk) begin
        if (!rst)
            r_bus_err <= 1'b0;
        else if (w_multi)
            r_bus_err <= 1'b1;
    end
`else
    assign w_bus = w_bus_pri;
`endif

    assign w_b = w_bus[DATA_W-1:0];

    always_comb begin
        w_alu = r_ac;
        case (alus)
            4'd0:    w_alu = w_b;
            4'd1:    w_alu = r_ac + w_b;
            4'd2:    w_alu = r_ac - w_b;
            4'd3:    w_alu = r_ac + C_ONE_D;
            4'd4:    w_alu = '0;
            4'd5:    w_alu = r_ac & w_b;
            4'd6:    w_alu = r_ac | w_b;
            4'd7:    w_alu = r_ac ^ w_b;
            4'd8:    w_alu = ~r_ac;
            default: w_alu = r_ac;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_ar <= '0;
            r_pc <= '0;
            r_dr <= '0;
            r_tr <= '0;
            r_ir <= '0;
            r_r  <= '0;
            r_ac <= '0;
            r_z  <= 1'b0;
        end else begin
            if (ARload)     r_ar <= w_bus;
            else if (ARinc) r_ar <= r_ar + C_ONE_A;
            if (PCload)     r_pc <= w_bus;
            else if (PCinc) r_pc <= r_pc + C_ONE_A;
            if (DRload)     r_dr <= w_b;
            // TR captures the pre-edge DR even when DR loads on the same edge.
            if (TRload)     r_tr <= r_dr;
            if (IRload)     r_ir <= w_b;
            if (Rload)      r_r  <= w_b;
            if (ACload)     r_ac <= w_alu;
            if (Zload)      r_z  <= (w_alu == '0);
        end
    end

    assign mem_addr  = r_ar;
    assign mem_wdata = w_b;
    assign mem_we    = bus2mem & ~mem2bus;
    assign instr     = r_ir;
    assign z         = r_z;
    assign ac        = r_ac;

endmodule
`default_nettype wire

// File: tb/tb_cpu_datapath.sv
`default_nettype none
// ============================================================================
// Module   : tb_cpu_datapath
// Purpose  : Scoreboard bench for cpu_datapath; expectations queued at drive
//            time and compared once the DUT result is due.
// Revision : 1.0  initial release
// ============================================================================
module tb_cpu_datapath;

    logic        clk = 1'b0;
    logic        rst;
    logic        ARload, ARinc, PCload, PCinc, DRload, TRload, IRload, Rload;
    logic        ACload, Zload, PCbus, DRhbus, DRlbus, TRbus, Rbus, ACbus;
    logic        mem2bus, bus2mem;
    logic [3:0]  alus;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_we;
    logic [7:0]  mem_rdata;
    logic [7:0]  instr;
    logic        z;
    logic [7:0]  ac;
`ifdef BUS_CHECK_EN
    logic        bus_err;
`endif

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        string       tag;
        int          sel;
        logic [15:0] val;
    } sb_t;
    sb_t sbq[$];

    localparam int S_ADDR = 0, S_INSTR = 1, S_AC = 2, S_Z = 3, S_WDATA = 4,
                   S_WE = 5, S_ERR = 6;

    cpu_datapath #(.DATA_W(8), .ADDR_W(16)) dut (
        .clk(clk), .rst(rst),
        .ARload(ARload), .ARinc(ARinc), .PCload(PCload), .PCinc(PCinc),
        .DRload(DRload), .TRload(TRload), .IRload(IRload), .Rload(Rload),
        .ACload(ACload), .Zload(Zload), .PCbus(PCbus), .DRhbus(DRhbus),
        .DRlbus(DRlbus), .TRbus(TRbus), .Rbus(Rbus), .ACbus(ACbus),
        .mem2bus(mem2bus), .bus2mem(bus2mem), .alus(alus),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
        .mem_rdata(mem_rdata), .instr(instr), .z(z),
`ifdef BUS_CHECK_EN
        .bus_err(bus_err),
`endif
        .ac(ac)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] observe(input int sel);
        case (sel)
            S_ADDR:  return mem_addr;
            S_INSTR: return {8'h00, instr};
            S_AC:    return {8'h00, ac};
            S_Z:     return {15'd0, z};
            S_WDATA: return {8'h00, mem_wdata};
            S_WE:    return {15'd0, mem_we};
`ifdef BUS_CHECK_EN
            S_ERR:   return {15'd0, bus_err};
`endif
            default: return 16'hxxxx;
        endcase
    endfunction

    function automatic logic [7:0] alu_model(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        case (op)
            4'd0: return b;
            4'd1: return 8'(a + b);
            4'd2: return 8'(a - b);
            4'd3: return 8'(a + 8'd1);
            4'd4: return 8'h00;
            4'd5: return a & b;
            4'd6: return a | b;
            4'd7: return a ^ b;
            4'd8: return ~a;
            default: return a;
        endcase
    endfunction

    task automatic expect_val(input string tag, input int sel, input logic [15:0] v);
        sb_t e;
        e.tag = tag; e.sel = sel; e.val = v;
        sbq.push_back(e);
    endtask

    task automatic drain();
        sb_t e;
        while (sbq.size() > 0) begin
            e = sbq.pop_front();
            check(e.tag, observe(e.sel), e.val);
        end
    endtask

    task automatic clr();
        {ARload, ARinc, PCload, PCinc, DRload, TRload, IRload, Rload} = '0;
        {ACload, Zload, PCbus, DRhbus, DRlbus, TRbus, Rbus, ACbus} = '0;
        {mem2bus, bus2mem} = '0;
        alus = 4'd0;
        mem_rdata = 8'h00;
    endtask

    // Registered results: compare 1 time unit after the active edge.
    task automatic step();
        @(posedge clk);
        #1;
        drain();
        clr();
    endtask

    // Combinational results: compare with controls still applied.
    task automatic settle();
        #1;
        drain();
        clr();
    endtask

    task automatic put_mem(input logic [7:0] v);
        mem_rdata = v;
        mem2bus   = 1'b1;
    endtask

    task automatic load_ac(input logic [7:0] v);
        put_mem(v); alus = 4'd0; ACload = 1'b1;
        step();
    endtask

    task automatic show_pc(input string tag, input logic [15:0] v);
        PCbus = 1'b1; ARload = 1'b1;
        expect_val(tag, S_ADDR, v);
        step();
    endtask

    initial begin
        logic [7:0] a, b, r;
        clr();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        expect_val("rst0_addr", S_ADDR, 16'h0000);
        expect_val("rst0_ac", S_AC, 16'h0000);
        drain();
        rst = 1'b1;

        // Reset: fill every register with nonzero data, then one reset edge.
        put_mem(8'hAA);
        {ARload, PCload, DRload, IRload, Rload, ACload} = '1;
        step();
        TRload = 1'b1;
        expect_val("fill_instr", S_INSTR, 16'h00AA);
        expect_val("fill_ac", S_AC, 16'h00AA);
        expect_val("fill_addr", S_ADDR, 16'h00AA);
        step();
        alus = 4'd4; Zload = 1'b1;
        expect_val("fill_z", S_Z, 16'h0001);
        step();
        rst = 1'b0; ACload = 1'b1; alus = 4'd3; PCinc = 1'b1; ARinc = 1'b1;
        expect_val("rst_instr", S_INSTR, 16'h0000);
        expect_val("rst_ac", S_AC, 16'h0000);
        expect_val("rst_z", S_Z, 16'h0000);
        expect_val("rst_addr", S_ADDR, 16'h0000);
        step();
        rst = 1'b1;
        DRlbus = 1'b1; expect_val("rst_dr", S_WDATA, 16'h0000); settle();
        TRbus = 1'b1;  expect_val("rst_tr", S_WDATA, 16'h0000); settle();
        Rbus = 1'b1;   expect_val("rst_r", S_WDATA, 16'h0000);  settle();
        show_pc("rst_pc", 16'h0000);

        // Fetch.
        put_mem(8'h05); PCload = 1'b1; step();
        show_pc("fetch_ar", 16'h0005);
        put_mem(8'h0A); DRload = 1'b1; PCinc = 1'b1;
        expect_val("fetch_ar_hold", S_ADDR, 16'h0005);
        step();
        DRlbus = 1'b1; IRload = 1'b1;
        expect_val("fetch_instr", S_INSTR, 16'h000A);
        step();
        show_pc("fetch_pc", 16'h0006);

        // ALU directed.
        load_ac(8'h7F);
        put_mem(8'h01); Rload = 1'b1; step();
        Rbus = 1'b1; alus = 4'd1; ACload = 1'b1; Zload = 1'b1;
        expect_val("add_ac", S_AC, 16'h0080);
        expect_val("add_z", S_Z, 16'h0000);
        step();
        put_mem(8'h80); alus = 4'd2; ACload = 1'b1; Zload = 1'b1;
        expect_val("sub_ac", S_AC, 16'h0000);
        expect_val("sub_z", S_Z, 16'h0001);
        step();
        // z follows alu_out of the same cycle, independent of ACload.
        load_ac(8'h05);
        alus = 4'd4; Zload = 1'b1;
        expect_val("zonly_z", S_Z, 16'h0001);
        expect_val("zonly_ac", S_AC, 16'h0005);
        step();

        // ALU sweep over every op code with random operands.
        for (int op = 0; op < 16; op++) begin
            a = 8'($urandom_range(1, 255));
            b = 8'($urandom);
            if (op == 8) a = 8'hFF;
            load_ac(a);
            put_mem(b); alus = 4'(op); ACload = 1'b1; Zload = 1'b1;
            r = alu_model(4'(op), a, b);
            expect_val($sformatf("alu%0d_ac", op), S_AC, {8'h00, r});
            expect_val($sformatf("alu%0d_z", op), S_Z, {15'd0, r == 8'h00});
            step();
        end

        // Wrap and load-over-increment priority.
        put_mem(8'hFF); DRload = 1'b1; step();
        put_mem(8'hFF); DRload = 1'b1; TRload = 1'b1; step();
        DRhbus = 1'b1; PCload = 1'b1; step();
        show_pc("pc_ffff", 16'hFFFF);
        ARinc = 1'b1; expect_val("ar_wrap", S_ADDR, 16'h0000); step();
        PCinc = 1'b1; step();
        show_pc("pc_wrap", 16'h0000);
        put_mem(8'h34); DRload = 1'b1; step();
        put_mem(8'h12); DRload = 1'b1; TRload = 1'b1; step();
        DRhbus = 1'b1; PCload = 1'b1; PCinc = 1'b1; step();
        show_pc("pc_load_win", 16'h1234);
        DRhbus = 1'b1; ARload = 1'b1; ARinc = 1'b1;
        expect_val("ar_load_win", S_ADDR, 16'h1234);
        step();

        // Store and memory strobe rules.
        put_mem(8'h40); ARload = 1'b1; step();
        load_ac(8'h5A);
        ACbus = 1'b1; bus2mem = 1'b1;
        expect_val("st_we", S_WE, 16'h0001);
        expect_val("st_addr", S_ADDR, 16'h0040);
        expect_val("st_wdata", S_WDATA, 16'h005A);
        settle();
        bus2mem = 1'b1;
        expect_val("idle_bus", S_WDATA, 16'h0000);
        settle();
        put_mem(8'h33); bus2mem = 1'b1;
        expect_val("illegal_we", S_WE, 16'h0000);
        settle();

        // Bus conflict.
        put_mem(8'h33); ACbus = 1'b1;
`ifdef BUS_CHECK_EN
        expect_val("pri_mem_ac", S_WDATA, 16'h0000);
`else
        expect_val("pri_mem_ac", S_WDATA, 16'h0033);
`endif
        settle();
        // Restore PC (clobbered only by AR-side tests above? no: still 0x1234).
        PCbus = 1'b1; ACbus = 1'b1; ARload = 1'b1;
`ifdef BUS_CHECK_EN
        expect_val("conf_ar", S_ADDR, 16'h0000);
        expect_val("conf_err", S_ERR, 16'h0001);
        step();
        expect_val("err_sticky", S_ERR, 16'h0001);
        step();
        rst = 1'b0;
        expect_val("err_clear", S_ERR, 16'h0000);
        step();
        rst = 1'b1;
`else
        expect_val("conf_ar", S_ADDR, 16'h1234);
        step();
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
`default_nettype wire
